// File: rtl/regfile_2r1w_if.sv
// Bus bundle for regfile_2r1w: one write port, two read ports, write-error pulse.
interface regfile_2r1w_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
);
    logic                  clr;
    logic                  w_en;
    logic [ADDR_W-1:0]     w_addr;
    logic [DATA_W-1:0]     w_data;
    logic [DATA_W/8-1:0]   w_be;
    logic                  w_err;

    logic                  ra_en;
    logic [ADDR_W-1:0]     ra_addr;
    logic [DATA_W-1:0]     ra_data;
    logic                  ra_valid;

    logic                  rb_en;
    logic [ADDR_W-1:0]     rb_addr;
    logic [DATA_W-1:0]     rb_data;
    logic                  rb_valid;

    modport master (
        output clr, w_en, w_addr, w_data, w_be, ra_en, ra_addr, rb_en, rb_addr,
        input  w_err, ra_data, ra_valid, rb_data, rb_valid
    );

    modport slave (
        input  clr, w_en, w_addr, w_data, w_be, ra_en, ra_addr, rb_en, rb_addr,
        output w_err, ra_data, ra_valid, rb_data, rb_valid
    );
endinterface

// File: rtl/regfile_2r1w.sv
// Parametrised 2-read / 1-write register file with byte-masked writes,
// registered reads, same-cycle write-to-read forwarding and synchronous clear.
module regfile_2r1w #(
    parameter int                DATA_W    = 8,
    parameter int                DEPTH     = 4,
    parameter int                ADDR_W    = $clog2(DEPTH),
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input logic           clk,
    input logic           rst_n,
    regfile_2r1w_if.slave bus
);
    localparam int             NBytes   = DATA_W / 8;
    // One extra bit so the range check also works when DEPTH is a power of 2.
    localparam logic [ADDR_W:0] DepthExt = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_ra_data;
    logic [DATA_W-1:0] r_rb_data;
    logic              r_ra_valid;
    logic              r_rb_valid;
    logic              r_w_err;

    logic [DATA_W-1:0] w_mask;
    logic              w_wr_in_range;
    logic              w_wr_hit;
    logic [DATA_W-1:0] w_cur_word;
    logic [DATA_W-1:0] w_wr_word;
    logic [DATA_W-1:0] w_ra_word;
    logic [DATA_W-1:0] w_rb_word;

    // Expand byte enables to a bit mask and build the merged write word.
    always_comb begin
        w_mask = '0;
        for (int k = 0; k < NBytes; k++) begin
            w_mask[8*k +: 8] = {8{bus.w_be[k]}};
        end
        w_wr_in_range = ({1'b0, bus.w_addr} < DepthExt);
        w_wr_hit      = bus.w_en && w_wr_in_range;
        w_cur_word    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.w_addr == ADDR_W'(i)) begin
                w_cur_word = r_mem[i];
            end
        end
        w_wr_word = (w_cur_word & ~w_mask) | (bus.w_data & w_mask);
    end

    // Read lookup per port; out-of-range addresses match no entry and give 0.
    // Forwarding ignores clr so a read in the clear cycle sees pre-clear data.
    always_comb begin
        w_ra_word = '0;
        w_rb_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.ra_addr == ADDR_W'(i)) begin
                w_ra_word = r_mem[i];
            end
            if (bus.rb_addr == ADDR_W'(i)) begin
                w_rb_word = r_mem[i];
            end
        end
        if (w_wr_hit && (bus.ra_addr == bus.w_addr)) begin
            w_ra_word = w_wr_word;
        end
        if (w_wr_hit && (bus.rb_addr == bus.w_addr)) begin
            w_rb_word = w_wr_word;
        end
    end

    // Storage update: clear wins over a same-cycle write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= RESET_VAL;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (bus.clr) begin
                    r_mem[i] <= RESET_VAL;
                end else if (w_wr_hit && (bus.w_addr == ADDR_W'(i))) begin
                    r_mem[i] <= w_wr_word;
                end
            end
        end
    end

    // Registered read ports; an idle port returns zero data and no valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ra_data  <= '0;
            r_ra_valid <= 1'b0;
            r_rb_data  <= '0;
            r_rb_valid <= 1'b0;
        end else begin
            r_ra_data  <= bus.ra_en ? w_ra_word : '0;
            r_ra_valid <= bus.ra_en;
            r_rb_data  <= bus.rb_en ? w_rb_word : '0;
            r_rb_valid <= bus.rb_en;
        end
    end

    // One-cycle error pulse for a write to a non-existent location.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w_err <= 1'b0;
        end else begin
            r_w_err <= bus.w_en && !w_wr_in_range;
        end
    end

    assign bus.ra_data  = r_ra_data;
    assign bus.ra_valid = r_ra_valid;
    assign bus.rb_data  = r_rb_data;
    assign bus.rb_valid = r_rb_valid;
    assign bus.w_err    = r_w_err;
endmodule

// File: doc/regfile_2r1w.md
# regfile_2r1w

Parametrised register file: one write port, two independent read ports. Reset is asynchronous active-low, reads are registered, writes can be byte-masked, and same-cycle write data is forwarded to the read ports. It is the general-purpose storage block for datapath and CSR-style designs, and replaces the fixed 4×8 single-port register file.

## Interface
Parameters:
- DATA_W, default 8: word width; must be a multiple of 8.
- DEPTH, default 4: number of registers; must be ≥ 2.
- ADDR_W, default $clog2(DEPTH): address width.
- RESET_VAL, default 0: value every register takes on reset and on clr.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear of all registers to RESET_VAL.
- w_en  in  1  write request.
- w_addr  in  ADDR_W  write address.
- w_data  in  DATA_W  write data.
- w_be  in  DATA_W/8  byte enables; bit k selects bits [8k+7:8k].
- ra_en  in  1  port A read request.
- ra_addr  in  ADDR_W  port A address.
- ra_data  out  DATA_W  port A read data.
- ra_valid  out  1  port A data valid.
- rb_en, rb_addr, rb_data, rb_valid: port B, identical to port A.
- w_err  out  1  one-cycle pulse: write addressed a location ≥ DEPTH.

## Operation
- Storage: DEPTH × DATA_W flops.
- Write: when w_en=1 and w_addr<DEPTH, update only the enabled byte lanes. Disabled lanes keep their value. w_be=0 is a legal no-op and raises no error.
- Out-of-range write (w_addr≥DEPTH, possible only when DEPTH is not a power of 2): the write is dropped and w_err=1 on the next cycle.
- Read (per port, independent): when x_en=1, x_data is loaded with the addressed word at the next edge and x_valid=1. When x_en=0, x_data=0 and x_valid=0 at the next edge.
- Out-of-range read returns 0 with x_valid=1.
- Forwarding: if a read and a write hit the same in-range address in the same cycle, the read returns the merged value. Enabled lanes come from w_data; the other lanes come from the stored word. The write still happens.
- Both ports may read the same address in the same cycle; both return the same value.
- clr=1: every register becomes RESET_VAL at the edge. clr has priority over a same-cycle write, and the write is lost.
  - A read in the clr cycle returns the pre-clear contents, including any forwarded write data.

## Timing
- Reset (rst_n=0, asynchronous assert, synchronous-safe deassert):
  - all registers = RESET_VAL;
  - ra_data = rb_data = 0;
  - ra_valid = rb_valid = 0;
  - w_err = 0.
- Write latency: stored at the edge where w_en=1. A read issued the following cycle returns the new value.
- Read latency: 1 cycle, from the x_en edge to x_data/x_valid. Back-to-back reads give one result per cycle.
- No backpressure. Requests are accepted every cycle.
- Reset asserted mid-operation: any in-flight read result is discarded, and outputs go to their reset values immediately, without waiting for a clock edge.
- First edge after rst_n rises: normal operation. A read issued in that cycle returns RESET_VAL.

## Test plan
- Reset: DATA_W=8, DEPTH=4, RESET_VAL=8'h5A.
  - Pulse rst_n low; read all 4 addresses on port A → each returns 8'h5A with ra_valid=1.
  - While reset is asserted, ra_data=0 and ra_valid=0.
- Byte-masked write: DATA_W=32. Write 32'hFFFF_FFFF to addr 1 with w_be=4'hF, then 32'h1234_5678 with w_be=4'b0101 → port B read of addr 1 returns 32'hFF34_FF78.
- Forwarding: addr 2 holds 8'h00. In the same cycle, write 8'hC3 to addr 2 and read addr 2 on both ports → ra_data = rb_data = 8'hC3 one cycle later. A read the following cycle also returns 8'hC3.
- Read enable low: drop ra_en after a valid read → next cycle ra_data=0 and ra_valid=0. Port B is unaffected while rb_en stays high.
- Out-of-range: DEPTH=5, ADDR_W=3.
  - Write to addr 6 → w_err=1 for exactly one cycle; no register changes.
  - Read addr 7 → data 0 with valid=1.
- clr vs write: in the same cycle, assert clr and write 8'hAA to addr 0 → addr 0 reads back RESET_VAL afterwards.
- Reset mid-operation: assert rst_n=0 asynchronously between edges while reads are active → outputs drop to 0 before the next edge.
